// File: rtl/mmio_timer_pkg.sv
// Shared definitions for the memory-mapped interval timer.
// Holds register offsets within the timer window, CTRL bit positions and
// the timer state encoding used by mmio_timer and timer_core.
package mmio_timer_pkg;

    // Register offsets, taken from ADDR[1:0]
    localparam logic [1:0] OFS_STATUS = 2'd0;
    localparam logic [1:0] OFS_CTRL   = 2'd1;
    localparam logic [1:0] OFS_PERIOD = 2'd2;
    localparam logic [1:0] OFS_SNAP   = 2'd3;

    // Bit positions inside a CTRL write
    localparam int unsigned B_CONT  = 0;
    localparam int unsigned B_START = 1;
    localparam int unsigned B_STOP  = 2;

    typedef enum logic {
        IDLE     = 1'b0,
        COUNTING = 1'b1
    } state_e;

endpackage

// File: rtl/mmio_timer_core.sv
// timer_core: down-counter and two-state run FSM of the interval timer.
// Ports:
//   clk, rst_n   - clock (rising edge), asynchronous active-low reset
//   start, stop  - one-cycle command pulses (stop has priority)
//   clr_to       - one-cycle request to clear the sticky timeout flag
//   cont         - auto-reload enable
//   period       - reload value; timeout period is period+1 cycles
//   count        - current counter value
//   run          - 1 while counting
//   to           - sticky timeout flag
module timer_core
    import mmio_timer_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic        clr_to,
    input  logic        cont,
    input  logic [15:0] period,
    output logic [15:0] count,
    output logic        run,
    output logic        to
);

    state_e      state_q, state_d;
    logic [15:0] count_q, count_d;
    logic        to_q, to_d;
    logic        terminal;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no
        // path leaves it unassigned and no latch is inferred.
        state_d  = state_q;
        count_d  = count_q;
        to_d     = to_q;
        terminal = (state_q == COUNTING) && (count_q == 16'd0);

        // Terminal count is applied after the software clear, so a clear
        // in the same cycle loses.
        if (clr_to) begin
            to_d = 1'b0;
        end
        if (terminal) begin
            to_d = 1'b1;
        end

        if (stop) begin
            state_d = IDLE;
        end else if (start) begin
            count_d = period;
            state_d = COUNTING;
        end else if (state_q == COUNTING) begin
            // Zero is checked before decrementing, so the count never wraps.
            if (!terminal) begin
                count_d = count_q - 16'd1;
            end else if (cont) begin
                count_d = period;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            to_q    <= to_d;
        end
    end

    assign count = count_q;
    assign run   = (state_q == COUNTING);
    assign to    = to_q;

endmodule

// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped interval timer on the data-memory port.
// Decodes a 4 KiB window selected by ADDR[15:12] == BASE, holds the CTRL,
// PERIOD and SNAP registers and returns registered read data one cycle
// after the address is presented.
// Ports:
//   Clock, Resetn - clock (rising edge), asynchronous active-low reset
//   ADDR          - processor address
//   DOUT          - processor write data
//   W             - write strobe
//   RDATA         - registered read data (0 when not selected)
//   SEL           - registered hit flag for the DIN mux
//   IRQ           - sticky timeout flag
module mmio_timer
    import mmio_timer_pkg::*;
#(
    parameter logic [3:0] BASE = 4'h3
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic [15:0] ADDR,
    input  logic [15:0] DOUT,
    input  logic        W,
    output logic [15:0] RDATA,
    output logic        SEL,
    output logic        IRQ
);

    logic        hit;
    logic [1:0]  ofs;
    logic        wr_status, wr_ctrl, wr_period, wr_snap;
    logic        start, stop;
    logic        cont_q, cont_d;
    logic [15:0] period_q, period_d;
    logic [15:0] snap_q, snap_d;
    logic [15:0] rdata_q, rdata_d;
    logic        sel_q, sel_d;
    logic [15:0] count;
    logic        run, to;

    // ADDR[11:2] is deliberately not decoded; the registers alias across
    // the whole window.
    logic unused_addr;
    assign unused_addr = ^ADDR[11:2];

    assign hit       = (ADDR[15:12] == BASE);
    assign ofs       = ADDR[1:0];
    assign wr_status = W && hit && (ofs == OFS_STATUS);
    assign wr_ctrl   = W && hit && (ofs == OFS_CTRL);
    assign wr_period = W && hit && (ofs == OFS_PERIOD);
    assign wr_snap   = W && hit && (ofs == OFS_SNAP);
    assign start     = wr_ctrl && DOUT[B_START];
    assign stop      = wr_ctrl && DOUT[B_STOP];

    timer_core u_core (
        .clk    (Clock),
        .rst_n  (Resetn),
        .start  (start),
        .stop   (stop),
        .clr_to (wr_status),
        .cont   (cont_q),
        .period (period_q),
        .count  (count),
        .run    (run),
        .to     (to)
    );

    always_comb begin
        cont_d   = wr_ctrl   ? DOUT[B_CONT] : cont_q;
        period_d = wr_period ? DOUT         : period_q;
        // Captures the count as it stands before this edge's decrement.
        snap_d   = wr_snap   ? count        : snap_q;

        // Read data reflects register contents before this edge's write.
        sel_d   = hit;
        rdata_d = '0;
        if (hit) begin
            unique case (ofs)
                OFS_STATUS: rdata_d = {14'b0, run, to};
                OFS_CTRL:   rdata_d = {15'b0, cont_q};
                OFS_PERIOD: rdata_d = period_q;
                OFS_SNAP:   rdata_d = snap_q;
                default:    rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            cont_q   <= 1'b0;
            period_q <= '0;
            snap_q   <= '0;
            rdata_q  <= '0;
            sel_q    <= 1'b0;
        end else begin
            cont_q   <= cont_d;
            period_q <= period_d;
            snap_q   <= snap_d;
            rdata_q  <= rdata_d;
            sel_q    <= sel_d;
        end
    end

    assign RDATA = rdata_q;
    assign SEL   = sel_q;
    assign IRQ   = to;

endmodule

// File: tb/tb_mmio_timer.sv
// Self-checking bench for mmio_timer: directed scenarios for reset, one-shot,
// auto-reload, collisions, snapshot and decode, followed by random bus
// traffic. Every cycle RDATA/SEL/IRQ are compared with a behavioural model.
module tb_mmio_timer;

    logic        Clock = 1'b0;
    logic        Resetn;
    logic [15:0] ADDR;
    logic [15:0] DOUT;
    logic        W;
    logic [15:0] RDATA;
    logic        SEL;
    logic        IRQ;

    mmio_timer #(.BASE(4'h3)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .ADDR   (ADDR),
        .DOUT   (DOUT),
        .W      (W),
        .RDATA  (RDATA),
        .SEL    (SEL),
        .IRQ    (IRQ)
    );

    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_pass   = 0;
    int edge_n   = 0;

    // Behavioural model of the programmer-visible state
    logic [15:0] m_count, m_period, m_snap, m_rdata;
    logic        m_run, m_to, m_cont, m_sel;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, edge_n);
    endtask

    task automatic model_reset();
        m_count = '0; m_period = '0; m_snap = '0; m_rdata = '0;
        m_run = 1'b0; m_to = 1'b0; m_cont = 1'b0; m_sel = 1'b0;
    endtask

    // One rising edge of the timer as seen by software.
    task automatic model_edge(input logic [15:0] a, input logic [15:0] d, input logic w);
        logic        hit, wr_en, tc;
        logic [1:0]  ofs;
        logic [15:0] old_count, old_period;
        logic        old_cont;
        hit = (a[15:12] == 4'h3);
        ofs = a[1:0];
        wr_en = w && hit;
        old_count = m_count; old_period = m_period; old_cont = m_cont;

        // Read data: contents before this edge
        m_sel = hit;
        m_rdata = 16'h0000;
        if (hit) begin
            if (ofs == 2'd0) m_rdata = {14'b0, m_run, m_to};
            else if (ofs == 2'd1) m_rdata = {15'b0, m_cont};
            else if (ofs == 2'd2) m_rdata = m_period;
            else m_rdata = m_snap;
        end

        // Timeout flag: a terminal count always sets, beating a clear
        tc = m_run && (m_count == 0);
        if (wr_en && ofs == 2'd0) m_to = 1'b0;
        if (tc) m_to = 1'b1;

        // Run/count behaviour
        if (wr_en && ofs == 2'd1 && d[2]) begin
            m_run = 1'b0;
        end else if (wr_en && ofs == 2'd1 && d[1]) begin
            m_count = old_period;
            m_run = 1'b1;
        end else if (m_run) begin
            if (m_count != 0) m_count = m_count - 1;
            else if (old_cont) m_count = old_period;
            else m_run = 1'b0;
        end

        // Register writes
        if (wr_en && ofs == 2'd1) m_cont = d[0];
        if (wr_en && ofs == 2'd2) m_period = d;
        if (wr_en && ofs == 2'd3) m_snap = old_count;
    endtask

    task automatic cyc(input logic [15:0] a, input logic [15:0] d, input logic w);
        @(negedge Clock);
        ADDR = a; DOUT = d; W = w;
        @(posedge Clock);
        edge_n++;
        model_edge(a, d, w);
        #1;
        check("rdata", RDATA, m_rdata);
        check("sel", SEL, m_sel);
        check("irq", IRQ, m_to);
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        cyc(a, d, 1'b1);
    endtask

    task automatic rd(input logic [15:0] a);
        cyc(a, 16'h0000, 1'b0);
    endtask

    // Reads STATUS until IRQ is seen; n is cycles taken, or limit+1 if never.
    task automatic wait_irq(input int limit, output int n);
        n = limit + 1;
        for (int i = 1; i <= limit; i++) begin
            rd(16'h3000);
            if (IRQ === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int n, e1, e2;
        logic [15:0] a, d;
        logic        w;

        Resetn = 1'b0; ADDR = '0; DOUT = '0; W = 1'b0;
        model_reset();
        #12;
        check("reset_rdata", RDATA, 16'h0);
        check("reset_sel", SEL, 1'b0);
        check("reset_irq", IRQ, 1'b0);
        @(negedge Clock);
        Resetn = 1'b1;

        // One-shot, PERIOD=5: IRQ rises 6 cycles after the START edge
        wr(16'h3002, 16'd5);
        wr(16'h3001, 16'h0002);
        wait_irq(20, n);
        check("oneshot_latency", n, 6);
        rd(16'h3000);
        check("oneshot_status", RDATA, 16'h0001);
        wr(16'h3003, 16'h0);
        rd(16'h3003);
        check("oneshot_count_held", RDATA, 16'h0);
        wr(16'h3000, 16'h0);

        // Auto-reload, PERIOD=3
        wr(16'h3002, 16'd3);
        wr(16'h3001, 16'h0003);
        wait_irq(20, n);
        check("reload_first", n, 4);
        e1 = edge_n;
        wr(16'h3000, 16'h0);
        check("status_clear", IRQ, 1'b0);
        wait_irq(20, n);
        e2 = edge_n;
        check("reload_interval", e2 - e1, 4);

        // Clear on the terminal-count cycle: set wins
        wr(16'h3000, 16'h0);
        rd(16'h3000);
        rd(16'h3000);
        wr(16'h3000, 16'h0);
        check("clear_vs_terminal", IRQ, 1'b1);

        // START and STOP together: STOP wins
        wr(16'h3001, 16'h0006);
        rd(16'h3000);
        check("start_stop_status", RDATA, 16'h0001);

        // Snapshot 10 cycles after START with PERIOD=100
        wr(16'h3000, 16'h0);
        wr(16'h3002, 16'd100);
        wr(16'h3001, 16'h0002);
        repeat (9) rd(16'h3000);
        wr(16'h3003, 16'h0);
        rd(16'h3003);
        check("snap_value", RDATA, 16'd91);
        check("snap_sel", SEL, 1'b1);

        // Decode: outside the window, and an alias inside it
        wr(16'h2002, 16'h1234);
        check("nonhit_sel", SEL, 1'b0);
        rd(16'h3002);
        check("nonhit_period", RDATA, 16'd100);
        wr(16'h3FF6, 16'h0042);
        rd(16'h3002);
        check("alias_period", RDATA, 16'h0042);

        // Reset in the middle of an auto-reload count
        wr(16'h3002, 16'd3);
        wr(16'h3001, 16'h0003);
        wait_irq(20, n);
        rd(16'h3000);
        #2;
        Resetn = 1'b0;
        #1;
        model_reset();
        check("midreset_rdata", RDATA, 16'h0);
        check("midreset_sel", SEL, 1'b0);
        check("midreset_irq", IRQ, 1'b0);
        @(negedge Clock);
        Resetn = 1'b1;
        rd(16'h3000);
        rd(16'h3002);
        check("after_reset_status", dut.RDATA == 16'h0 ? 1'b0 : 1'b1, 1'b0);
        rd(16'h3000);
        check("after_reset_status_read", RDATA, 16'h0);

        // Random bus traffic
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 9) < 8) a = {4'h3, 10'($urandom), 2'($urandom)};
            else a = {4'($urandom_range(4, 15)), 12'($urandom)};
            w = ($urandom_range(0, 2) == 0);
            d = 16'($urandom);
            if (a[15:12] == 4'h3 && a[1:0] == 2'd2) d = 16'($urandom_range(0, 12));
            if (a[15:12] == 4'h3 && a[1:0] == 2'd1) d = 16'($urandom_range(0, 7));
            cyc(a, d, w);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
